memp_router_stage: RTL

Parametrised memory-prepare stage for the 8-stage pipeline, sitting between EX and MEMD. It decodes each load/store from EX onto one of `NCH` target channels (DRAM, system bus, further peripheral ports) using a per-channel base-address table. Each request is driven over a valid/ready handshake, so multi-cycle targets are supported, and the block raises a stall request upstream while a target is not ready. It also checks natural alignment and flags misaligned accesses to MEMD instead of issuing them.

---
 rtl/memp_router_stage.sv | 134 +++++++++++++
 1 files changed

// File: rtl/memp_router_stage.sv
// Memory-prepare stage between EX and MEMD: decodes each load/store onto one of
// NCH target channels, drives it over valid/ready, and flags misaligned accesses.
module memp_router_stage #(
   parameter int                     NCH         = 2,
   parameter int                     XLEN        = 64,
   parameter logic [NCH*XLEN-1:0]    REGION_BASE = {64'h8000_0000, 64'h0},
   localparam int                    CH_W        = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall_in,
   input  logic             flush,
   input  logic             valid_EXC,
   input  logic [XLEN-1:0]  pc_EXC,
   input  logic [XLEN-1:0]  alu_result_EXC,
   input  logic [XLEN-1:0]  reg_data2_EXC,
   input  logic [2:0]       dm_rd_ctrl_EXC,
   input  logic [2:0]       dm_wr_ctrl_EXC,
   input  logic             rf_wr_en_EXC,
   input  logic [1:0]       rf_wr_sel_EXC,
   input  logic [4:0]       rd_EXC,
   output logic [NCH-1:0]   ch_req_valid,
   input  logic [NCH-1:0]   ch_req_ready,
   output logic [XLEN-1:0]  ch_addr,
   output logic [XLEN-1:0]  ch_din,
   output logic [2:0]       ch_rd_ctrl,
   output logic [2:0]       ch_wr_ctrl,
   output logic             stall_req,
   output logic             valid_MEMP,
   output logic [XLEN-1:0]  pc_MEMP,
   output logic [XLEN-1:0]  alu_result_MEMP,
   output logic             rf_wr_en_MEMP,
   output logic [1:0]       rf_wr_sel_MEMP,
   output logic [4:0]       rd_MEMP,
   output logic [CH_W-1:0]  ch_sel_MEMP,
   output logic             misalign_MEMP
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t           state_q, state_d;
   logic [CH_W-1:0]  sel, sel_q;
   logic             killed_q;
   logic             is_wr, mem_op, misalign, accept;
   logic [2:0]       ctrl_eff, size_mask;

   // A store wins when both controls are set; its code then sets the access size.
   assign is_wr    = (dm_wr_ctrl_EXC != 3'd0);
   assign ctrl_eff = is_wr ? dm_wr_ctrl_EXC : dm_rd_ctrl_EXC;
   assign mem_op   = (ctrl_eff != 3'd0);

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      size_mask = 3'b000;
      case (ctrl_eff)
         3'd3, 3'd4: size_mask = 3'b001;
         3'd5, 3'd6: size_mask = 3'b011;
         3'd7:       size_mask = 3'b111;
         default:    size_mask = 3'b000;
      endcase
   end

   assign misalign = mem_op && ((alu_result_EXC[2:0] & size_mask) != 3'b000);

   // Ascending bases: the last region whose base is not above the address wins.
   always_comb begin
      sel = '0;
      for (int i = 0; i < NCH; i++) begin
         if (alu_result_EXC >= REGION_BASE[i*XLEN +: XLEN]) sel = CH_W'(i);
      end
   end

   assign accept = (state_q != REQ) && valid_EXC && !stall_in && !flush;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: begin
            if (accept)                state_d = (mem_op && !misalign) ? REQ : DONE;
            else if (state_q == DONE)  state_d = IDLE;
         end
         REQ:     if (ch_req_ready[sel_q]) state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   assign ch_req_valid = (state_q == REQ) ? (NCH'(1) << sel_q) : '0;
   assign stall_req    = (state_q == REQ) && !ch_req_ready[sel_q];
   assign valid_MEMP   = (state_q == DONE) && !killed_q;
   assign ch_sel_MEMP  = sel_q;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q         <= IDLE;
         sel_q           <= '0;
         killed_q        <= 1'b0;
         pc_MEMP         <= '0;
         alu_result_MEMP <= '0;
         rf_wr_en_MEMP   <= 1'b0;
         rf_wr_sel_MEMP  <= '0;
         rd_MEMP         <= '0;
         misalign_MEMP   <= 1'b0;
         ch_addr         <= '0;
         ch_din          <= '0;
         ch_rd_ctrl      <= '0;
         ch_wr_ctrl      <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            sel_q           <= sel;
            killed_q        <= 1'b0;
            pc_MEMP         <= pc_EXC;
            alu_result_MEMP <= alu_result_EXC;
            rf_wr_en_MEMP   <= rf_wr_en_EXC && !misalign;
            rf_wr_sel_MEMP  <= rf_wr_sel_EXC;
            rd_MEMP         <= rd_EXC;
            misalign_MEMP   <= misalign;
            if (mem_op && !misalign) begin
               ch_addr    <= alu_result_EXC;
               ch_din     <= reg_data2_EXC;
               ch_rd_ctrl <= is_wr ? 3'd0 : dm_rd_ctrl_EXC;
               ch_wr_ctrl <= dm_wr_ctrl_EXC;
            end
         end else if (flush && (state_q != IDLE)) begin
            // Killed slot: the bus transfer in flight still completes, writeback does not.
            rf_wr_en_MEMP <= 1'b0;
            misalign_MEMP <= 1'b0;
            killed_q      <= 1'b1;
         end
      end
   end

endmodule
